// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch unit.
//   - state_t     : fetch FSM states (IDLE, FETCH, HOLD, DRAIN)
//   - PC_W        : program counter width
//   - DEFAULT_*   : default reset address and sequential step
//   - ALIGN_MASK  : clears bits [1:0] to force word alignment
//   - align_pc()  : applies ALIGN_MASK to an address
package fetch_pkg;

  localparam int PC_W = 32;

  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [PC_W-1:0] DEFAULT_PC_STEP  = 32'd4;
  localparam logic [PC_W-1:0] ALIGN_MASK       = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: the fetch program counter register.
// Ports:
//   clk     - rising-edge clock
//   rst_n   - asynchronous active-low reset, loads RESET_PC
//   load    - capture next_pc on the next rising edge
//   next_pc - value to load
//   pc      - current program counter
// Next-value selection lives in the caller; this block only stores.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [PC_W-1:0] next_pc,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= next_pc;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch between the PC state and decode.
// Owns the fetch PC, keeps at most one read open to instruction memory,
// and presents each returned instruction with its PC to decode. Redirects
// reposition the PC; anything fetched on the old path is discarded.
//
// Ports:
//   Clk         - rising-edge clock
//   Reset       - asynchronous active-low reset
//   Redirect    - load RedirectPc (low two bits ignored) as next fetch PC
//   RedirectPc  - redirect target
//   MemReq      - read request, open until MemAck
//   MemAddr     - word-aligned read address
//   MemAck      - one-cycle acknowledge, MemRdata valid in that cycle
//   MemRdata    - returned instruction word
//   InstrValid  - Instr/InstrPc valid for decode
//   Instr       - fetched instruction
//   InstrPc     - address Instr came from
//   InstrReady  - decode accepts this cycle
//   Pc          - current fetch PC
//   DbgState    - FSM state, for observation only
//
// Handshakes: memory side is req/ack -- MemReq stays high with MemAddr
// stable until the cycle MemAck is seen, which completes the read. Decode
// side is valid/ready -- a transfer happens on a rising edge where
// InstrValid && InstrReady; Instr/InstrPc are stable while InstrValid is
// high and not yet accepted. A Redirect in the same cycle cancels it.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [PC_W-1:0] PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Redirect,
  input  logic [PC_W-1:0] RedirectPc,
  output logic            MemReq,
  output logic [PC_W-1:0] MemAddr,
  input  logic            MemAck,
  input  logic [PC_W-1:0] MemRdata,
  output logic            InstrValid,
  output logic [PC_W-1:0] Instr,
  output logic [PC_W-1:0] InstrPc,
  input  logic            InstrReady,
  output logic [PC_W-1:0] Pc,
  output logic [1:0]      DbgState
);

  state_t          state;
  state_t          state_next;
  logic            pc_load;
  logic [PC_W-1:0] pc_next;
  logic            capture;
  logic            pend_load;
  logic [PC_W-1:0] pending;
  logic [PC_W-1:0] target;

  assign target = align_pc(RedirectPc);

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk     (Clk),
    .rst_n   (Reset),
    .load    (pc_load),
    .next_pc (pc_next),
    .pc      (Pc)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_load    = 1'b0;
    pc_next    = Pc;
    capture    = 1'b0;
    pend_load  = 1'b0;
    case (state)
      S_IDLE: begin
        state_next = S_FETCH;
        if (Redirect) begin
          pc_load = 1'b1;
          pc_next = target;
        end
      end
      S_FETCH: begin
        if (MemAck) begin
          pc_load = 1'b1;
          if (Redirect) begin
            // Returned word belongs to the old path; refetch at target.
            pc_next = target;
          end else begin
            pc_next    = Pc + PC_STEP;
            capture    = 1'b1;
            state_next = S_HOLD;
          end
        end else if (Redirect) begin
          // The open read cannot be withdrawn: park the target until the
          // stale ack arrives so MemAddr stays stable meanwhile.
          pend_load  = 1'b1;
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (Redirect) begin
          pend_load = 1'b1;
        end
        if (MemAck) begin
          pc_load    = 1'b1;
          pc_next    = Redirect ? target : pending;
          state_next = S_FETCH;
        end
      end
      S_HOLD: begin
        if (Redirect) begin
          pc_load    = 1'b1;
          pc_next    = target;
          state_next = S_FETCH;
        end else if (InstrReady) begin
          state_next = S_FETCH;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Instr   <= '0;
      InstrPc <= '0;
      pending <= '0;
    end else begin
      if (capture) begin
        Instr   <= MemRdata;
        InstrPc <= Pc;
      end
      if (pend_load) begin
        pending <= target;
      end
    end
  end

  // Pc only moves when a read completes or outside a read, so it is also
  // the address of the open request (including the stale one in DRAIN).
  assign MemReq     = (state == S_FETCH) || (state == S_DRAIN);
  assign MemAddr    = Pc;
  assign InstrValid = (state == S_HOLD);
  assign DbgState   = state;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic [31:0] pc;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];

  // Reference model: tracks whether fetching has started, whether a read is
  // open, whether that read's data is stale, and whether an instruction is
  // waiting for decode.
  bit          m_started;
  bit          m_busy;
  bit          m_stale;
  bit          m_have;
  logic [31:0] m_pc;
  logic [31:0] m_target;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;

  fetch_unit dut (
    .Clk        (clk),
    .Reset      (rst_n),
    .Redirect   (redirect),
    .RedirectPc (redirect_pc),
    .MemReq     (mem_req),
    .MemAddr    (mem_addr),
    .MemAck     (mem_ack),
    .MemRdata   (mem_rdata),
    .InstrValid (instr_valid),
    .Instr      (instr),
    .InstrPc    (instr_pc),
    .InstrReady (instr_ready),
    .Pc         (pc),
    .DbgState   (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic m_reset();
    m_started = 0;
    m_busy    = 0;
    m_stale   = 0;
    m_have    = 0;
    m_pc      = 32'h0;
    m_target  = 32'h0;
    m_instr   = 32'h0;
    m_ipc     = 32'h0;
  endtask

  task automatic m_step();
    logic [31:0] rpc;
    rpc = redirect_pc & 32'hFFFF_FFFC;
    if (!m_started) begin
      m_started = 1;
      m_busy    = 1;
      if (redirect) m_pc = rpc;
    end else if (m_have) begin
      if (redirect) begin
        m_have = 0; m_busy = 1; m_pc = rpc;
      end else if (instr_ready) begin
        m_have = 0; m_busy = 1; exp_q.push_back(m_instr);
      end
    end else if (m_busy && !m_stale) begin
      if (mem_ack && redirect) begin
        m_pc = rpc;
      end else if (mem_ack) begin
        m_instr = mem_rdata; m_ipc = m_pc; m_pc = m_pc + 32'd4;
        m_busy = 0; m_have = 1;
      end else if (redirect) begin
        m_stale = 1; m_target = rpc;
      end
    end else if (m_busy) begin
      if (redirect) m_target = rpc;
      if (mem_ack) begin
        m_pc = m_target; m_stale = 0;
      end
    end
  endtask

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    mem_ack     = 1'b0;
    mem_rdata   = 32'h0;
    instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    m_reset();
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  // Zero-wait memory: acknowledge any open request immediately.
  task automatic zw();
    mem_ack   = mem_req;
    mem_rdata = 32'h1111_0000 + mem_addr;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0; instr_ready = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({mem_req, mem_addr, instr_valid, instr, instr_pc, pc} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0}) begin
      n_err++;
      $display("FAIL reset_values: got req=%b addr=%h v=%b instr=%h ipc=%h pc=%h want all zero",
               mem_req, mem_addr, instr_valid, instr, instr_pc, pc);
    end
    m_reset();
    exp_q.delete();
    rst_n = 1'b1;
    n_vec++;
    if (mem_req !== 1'b0) begin
      n_err++; $display("FAIL idle_no_req: got %b want 0", mem_req);
    end
    cycle();
    n_vec++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h0}) begin
      n_err++; $display("FAIL first_req: got req=%b addr=%h want req=1 addr=0", mem_req, mem_addr);
    end
  endtask

  task automatic test_sequential();
    apply_reset();
    instr_ready = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      bit exp_v;
      exp_v = (k >= 2) && (k % 2 == 0);
      n_vec++;
      if (instr_valid !== exp_v) begin
        n_err++; $display("FAIL seq_valid[%0d]: got %b want %b", k, instr_valid, exp_v);
      end
      if (exp_v) begin
        logic [31:0] exp_pc;
        exp_pc = 32'(k / 2 - 1) * 32'd4;
        n_vec++;
        if ({instr_pc, instr} !== {exp_pc, 32'h1111_0000 + exp_pc}) begin
          n_err++;
          $display("FAIL seq_instr[%0d]: got pc=%h instr=%h want pc=%h instr=%h",
                   k, instr_pc, instr, exp_pc, 32'h1111_0000 + exp_pc);
        end
      end
      zw();
      cycle();
    end
  endtask

  task automatic test_hold_stall();
    apply_reset();
    instr_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      zw();
      cycle();
    end
    instr_ready = 1'b0;
    zw();
    for (int k = 0; k < 5; k++) begin
      n_vec++;
      if ({instr_valid, instr_pc, instr, mem_req, pc} !== {1'b1, 32'h8, 32'h1111_0008, 1'b0, 32'hC}) begin
        n_err++;
        $display("FAIL hold_stable[%0d]: got v=%b ipc=%h instr=%h req=%b pc=%h want v=1 ipc=8 instr=11110008 req=0 pc=c",
                 k, instr_valid, instr_pc, instr, mem_req, pc);
      end
      cycle();
      zw();
    end
    instr_ready = 1'b1;
    cycle();
    n_vec++;
    if ({mem_req, mem_addr} !== {1'b1, 32'hC}) begin
      n_err++; $display("FAIL hold_release: got req=%b addr=%h want req=1 addr=c", mem_req, mem_addr);
    end
  endtask

  task automatic test_drain();
    apply_reset();
    instr_ready = 1'b1;
    cycle();                       // IDLE -> request at 0
    mem_ack = 1'b0;
    cycle();                       // wait cycle 1
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if ({mem_req, mem_addr, instr_valid} !== {1'b1, 32'h0, 1'b0}) begin
        n_err++;
        $display("FAIL drain_addr[%0d]: got req=%b addr=%h v=%b want req=1 addr=0 v=0",
                 k, mem_req, mem_addr, instr_valid);
      end
      if (k == 2) begin
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      end
      cycle();
      redirect = 1'b0;
    end
    mem_ack = 1'b0;
    n_vec++;
    if ({mem_req, mem_addr, instr_valid, pc} !== {1'b1, 32'h100, 1'b0, 32'h100}) begin
      n_err++;
      $display("FAIL drain_target: got req=%b addr=%h v=%b pc=%h want req=1 addr=100 v=0 pc=100",
               mem_req, mem_addr, instr_valid, pc);
    end
  endtask

  task automatic test_redirect_hold();
    apply_reset();
    instr_ready = 1'b1;
    zw(); cycle();
    zw(); cycle();
    redirect = 1'b1; redirect_pc = 32'h40; mem_ack = 1'b0;
    cycle();
    redirect = 1'b0;
    n_vec++;
    if ({mem_req, mem_addr, instr_valid} !== {1'b1, 32'h40, 1'b0}) begin
      n_err++;
      $display("FAIL redir_hold_req: got req=%b addr=%h v=%b want req=1 addr=40 v=0",
               mem_req, mem_addr, instr_valid);
    end
    zw(); cycle();
    n_vec++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h40, 32'h1111_0040}) begin
      n_err++;
      $display("FAIL redir_hold_next: got v=%b ipc=%h instr=%h want v=1 ipc=40 instr=11110040",
               instr_valid, instr_pc, instr);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    instr_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    cycle();
    redirect = 1'b0;
    n_vec++;
    if ({mem_req, mem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      n_err++; $display("FAIL wrap_align: got req=%b addr=%h want req=1 addr=fffffffc", mem_req, mem_addr);
    end
    zw(); cycle();
    n_vec++;
    if ({instr_valid, instr_pc, instr, pc} !== {1'b1, 32'hFFFF_FFFC, 32'h1110_FFFC, 32'h0}) begin
      n_err++;
      $display("FAIL wrap_hold: got v=%b ipc=%h instr=%h pc=%h want v=1 ipc=fffffffc instr=1110fffc pc=0",
               instr_valid, instr_pc, instr, pc);
    end
    mem_ack = 1'b0;
    cycle();
    n_vec++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h0}) begin
      n_err++; $display("FAIL wrap_next: got req=%b addr=%h want req=1 addr=0", mem_req, mem_addr);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    instr_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h80;
    cycle();                       // request at 0x80
    redirect = 1'b0;
    zw(); cycle();                 // hold 0x80
    mem_ack = 1'b0; cycle();       // request at 0x84
    redirect = 1'b1; redirect_pc = 32'h200;
    cycle();                       // now draining the 0x84 read
    redirect = 1'b0;
    n_vec++;
    if ({mem_req, mem_addr, instr_pc} !== {1'b1, 32'h84, 32'h80}) begin
      n_err++;
      $display("FAIL areset_pre: got req=%b addr=%h ipc=%h want req=1 addr=84 ipc=80", mem_req, mem_addr, instr_pc);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({mem_req, mem_addr, instr_valid, instr, instr_pc, pc} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0}) begin
      n_err++;
      $display("FAIL areset_values: got req=%b addr=%h v=%b instr=%h ipc=%h pc=%h want all zero",
               mem_req, mem_addr, instr_valid, instr, instr_pc, pc);
    end
    @(negedge clk);
    m_reset();
    exp_q.delete();
    rst_n = 1'b1;
    cycle();
    n_vec++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h0}) begin
      n_err++; $display("FAIL areset_restart: got req=%b addr=%h want req=1 addr=0", mem_req, mem_addr);
    end
  endtask

  task automatic test_random();
    int          wcnt;
    int          lat;
    bit          hs;
    logic [31:0] hs_instr;
    bit          req_b;
    bit          ack_b;
    apply_reset();
    wcnt = 0;
    lat  = $urandom_range(0, 3);
    for (int k = 0; k < 600; k++) begin
      n_vec++;
      if ({mem_req, mem_addr, instr_valid, instr, instr_pc, pc} !==
          {m_busy, m_pc, m_have, m_instr, m_ipc, m_pc}) begin
        n_err++;
        $display("FAIL rand_out[%0d]: got req=%b addr=%h v=%b instr=%h ipc=%h pc=%h want req=%b addr=%h v=%b instr=%h ipc=%h pc=%h",
                 k, mem_req, mem_addr, instr_valid, instr, instr_pc, pc,
                 m_busy, m_pc, m_have, m_instr, m_ipc, m_pc);
      end
      redirect = ($urandom_range(0, 7) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
      instr_ready = ($urandom_range(0, 2) != 0);
      mem_ack = mem_req && (wcnt >= lat);
      mem_rdata = $urandom;
      hs = instr_valid && instr_ready && !redirect;
      hs_instr = instr;
      req_b = mem_req;
      ack_b = mem_ack;
      cycle();
      if (hs) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL rand_accept[%0d]: got instr=%h accepted want no accept", k, hs_instr);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (hs_instr !== e) begin
            n_err++; $display("FAIL rand_accept[%0d]: got instr=%h want %h", k, hs_instr, e);
          end
        end
      end
      if (req_b && ack_b) begin
        wcnt = 0;
        lat  = $urandom_range(0, 3);
      end else if (req_b) begin
        wcnt++;
      end
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL rand_leftover: got %0d unaccepted expected entries want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_hold_stall();
    test_drain();
    test_redirect_hold();
    test_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
